data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised data-memory stage for the RISC-V core, the successor to the fixed 21-word memory stage.
//  Serves LB/LH/LW/LBU/LHU/SB/SH/SW with byte lanes and sign/zero extension.
//  Uses a req/ready handshake, a registered 1-cycle response and misalign/range error reporting.
//  After reset, an optional clear FSM zeroes the whole array before it accepts any traffic.
// PARAMETERS
//  DEPTH           256  number of 32-bit words; ADDR_W = $clog2(DEPTH)
//  CLEAR_ON_RESET  1    1: run CLEAR state after reset; 0: go straight to IDLE (contents undefined)
// PORTS
//  clk          in   1   clock; all state changes on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  req_i        in   1   request valid
//  we_i         in   1   1 = store, 0 = load
//  size_i       in   2   00 byte, 01 half, 10 word, 11 reserved
//  unsigned_i   in   1   loads only: 1 = zero-extend, 0 = sign-extend
//  addr_i       in   32  byte address
//  wdata_i      in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  ready_o      out  1   block can accept a request this cycle
//  rsp_valid_o  out  1   one-cycle pulse, one per accepted request
//  rdata_o      out  32  load result; valid when rsp_valid_o=1 and err_o=0
//  err_o        out  1   request rejected; qualified by rsp_valid_o
//  init_done_o  out  1   1 once CLEAR has finished (or immediately if CLEAR_ON_RESET=0)
// BEHAVIOUR
//  Reset (rst_n=0, async): rsp_valid_o=0, rdata_o=0, err_o=0, clear counter=0.
//   CLEAR_ON_RESET=1: state=CLEAR, ready_o=0, init_done_o=0.
//   CLEAR_ON_RESET=0: state=IDLE, ready_o=1, init_done_o=1.
//   The array itself is not reset.
//  FSM CLEAR: each cycle writes mem[cnt]=0 and increments cnt.
//   When cnt==DEPTH-1, that write completes and state moves to IDLE on the same edge.
//   CLEAR therefore lasts exactly DEPTH cycles. ready_o=0 throughout; req_i is ignored, not queued.
//  FSM IDLE: ready_o=1 and init_done_o=1. No return to CLEAR except through reset.
//   Reset asserted mid-CLEAR aborts the clear; CLEAR restarts from word 0 after release.
//  Accept: request is accepted on a posedge where req_i && ready_o. At most one request per cycle.
//  Latency: rsp_valid_o=1 exactly on the cycle after accept, otherwise 0.
//   Back-to-back accepts give back-to-back rsp_valid_o pulses.
//  Index: word index = addr_i[ADDR_W+1:2]; lane = addr_i[1:0].
//  Errors: err=1 when any of the following holds:
//   (a) size_i==11
//   (b) half with addr_i[0]=1
//   (c) word with addr_i[1:0]!=0
//   (d) addr_i[31:2] >= DEPTH
//  On err: no array write, rdata_o=0, err_o=1 with the response.
//  Store: committed at the accept edge; only the enabled byte lanes change.
//   SB: lane = addr[1:0], takes wdata_i[7:0].
//   SH: lanes {addr[1],1'b0} and {addr[1],1'b1}, take wdata_i[15:0].
//   SW: all four lanes.
//   Store response: rdata_o=0, err_o=0.
//  Load: the word is read at the accept edge; lane extraction and extension are registered into rdata_o.
//   Byte: bits 31:8 are all zero (unsigned) or all copies of bit 7 (signed).
//   Half: bits 31:16 are all zero (unsigned) or all copies of bit 15 (signed).
//   Word: unsigned_i is ignored.
//  Hazard: a load accepted the cycle after a store to the same word returns the new data.
//   This holds because the store has already committed.
//  Between responses rdata_o and err_o hold their last values. Consumers must qualify them with rsp_valid_o.
//  Byte order is little-endian: lane 0 = bits [7:0].
// TESTING
//  T1 reset, CLEAR_ON_RESET=1, DEPTH=256: ready_o=0 for 256 cycles, then ready_o=init_done_o=1.
//   A LW to any in-range aligned address then returns 0x00000000.
//  T2 SW 0x8040_20F1 @0x10; then LB @0x10 -> 0xFFFFFFF1; LBU @0x13 -> 0x00000080;
//   LH @0x12 -> 0xFFFF8040; LHU @0x10 -> 0x000020F1.
//  T3 SB 0xAA @0x21 over word 0x11223344 @0x20; LW @0x20 -> 0x1122AA44.
//   SH 0xBEEF @0x22; LW -> 0xBEEFAA44.
//  T4 LH @0x03, SW @0x06, size_i=11, LW @(DEPTH*4): each gives rsp_valid_o=1, err_o=1, rdata_o=0.
//   A following LW of the targeted words shows them unchanged.
//  T5 back-to-back with req_i held high: SW 0x5 @0x40 then LW @0x40 on consecutive cycles.
//   Expect two consecutive rsp_valid_o pulses; the second carries 0x00000005.
//  T6 assert rst_n=0 at clear count 100, release, then hold req_i=1 throughout.
//   Expect no rsp_valid_o until a fresh 256-cycle CLEAR completes, then the first response.

Source files
------------

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl
//  Description : Parametrised data-memory stage. Serves byte/half/word loads
//                and stores with lane enables and sign/zero extension behind
//                a req/ready handshake. Responses are registered one cycle
//                after accept. Optionally zeroes the array after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int DEPTH          = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        rsp_valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        init_done_o
);

  localparam int          ADDR_W  = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_U = DEPTH;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [31:0]         mem [0:DEPTH-1];

  logic                w_accept;
  logic                w_err;
  logic [ADDR_W-1:0]   w_idx;
  logic [1:0]          w_lane;
  logic [31:0]         w_rword;
  logic [7:0]          w_rbyte;
  logic [15:0]         w_rhalf;
  logic [31:0]         w_ldata;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_widx;
  logic [3:0]          w_be;
  logic [31:0]         w_wdat;

  assign w_accept = req_i && ready_o;
  assign w_idx    = addr_i[ADDR_W+1:2];
  assign w_lane   = addr_i[1:0];
  assign w_rword  = mem[w_idx];

  // Reject reserved size, misaligned half/word and out-of-range word index
  always_comb begin
    w_err = 1'b0;
    if (size_i == 2'b11)                        w_err = 1'b1;
    if (size_i == 2'b01 && addr_i[0])           w_err = 1'b1;
    if (size_i == 2'b10 && addr_i[1:0] != 2'b00) w_err = 1'b1;
    if ({2'b00, addr_i[31:2]} >= DEPTH_U)       w_err = 1'b1;
  end

  // State and clear-counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: CLEAR walks every word once, then IDLE forever until reset
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_o     = 1'b0;
    init_done_o = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        ready_o     = 1'b1;
        init_done_o = 1'b1;
      end
    endcase
  end

  // Write-port control: zeroing during CLEAR, lane-enabled store otherwise
  always_comb begin
    w_mem_we = 1'b0;
    w_widx   = w_idx;
    w_be     = 4'b0000;
    w_wdat   = '0;
    if (state_q == ST_CLEAR) begin
      w_mem_we = rst_n;
      w_widx   = cnt_q;
      w_be     = 4'b1111;
    end else if (w_accept && we_i && !w_err) begin
      w_mem_we = rst_n;
      case (size_i)
        2'b00: begin
          w_be   = 4'b0001 << w_lane;
          w_wdat = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          w_be   = addr_i[1] ? 4'b1100 : 4'b0011;
          w_wdat = {2{wdata_i[15:0]}};
        end
        default: begin
          w_be   = 4'b1111;
          w_wdat = wdata_i;
        end
      endcase
    end
  end

  // Array write: only enabled byte lanes change; the array has no reset
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) mem[w_widx][8*b +: 8] <= w_wdat[8*b +: 8];
      end
    end
  end

  // Lane extraction and extension of the addressed word (little-endian)
  always_comb begin
    case (w_lane)
      2'd0:    w_rbyte = w_rword[7:0];
      2'd1:    w_rbyte = w_rword[15:8];
      2'd2:    w_rbyte = w_rword[23:16];
      default: w_rbyte = w_rword[31:24];
    endcase
    w_rhalf = addr_i[1] ? w_rword[31:16] : w_rword[15:0];
    case (size_i)
      2'b00:   w_ldata = unsigned_i ? {24'h0, w_rbyte} : {{24{w_rbyte[7]}}, w_rbyte};
      2'b01:   w_ldata = unsigned_i ? {16'h0, w_rhalf} : {{16{w_rhalf[15]}}, w_rhalf};
      default: w_ldata = w_rword;
    endcase
  end

  // Response next-state: data and error hold between responses
  always_comb begin
    rsp_valid_d = w_accept;
    rdata_d     = rdata_q;
    err_d       = err_q;
    if (w_accept) begin
      err_d   = w_err;
      rdata_d = (w_err || we_i) ? 32'h0 : w_ldata;
    end
  end

  // Registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_data_mem_ctrl
//  Description : Randomised scoreboard bench for data_mem_ctrl with a
//                byte-addressed reference model of the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        unsigned_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        ready_o;
  logic        rsp_valid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        init_done_o;

  data_mem_ctrl #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .we_i        (we_i),
    .size_i      (size_i),
    .unsigned_i  (unsigned_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .ready_o     (ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .init_done_o (init_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  mdl [DEPTH*4];

  // Reference model: byte-addressed memory and the access rules
  function automatic logic mdl_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [1:0] sz, input logic u,
                                           input logic [31:0] a);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = {24'h0, mdl[a]};
      if (!u && mdl[a][7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = {16'h0, mdl[a+1], mdl[a]};
      if (!u && mdl[a+1][7]) v = v | 32'hFFFF_0000;
    end else begin
      v = {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]};
    end
    return v;
  endfunction

  task automatic mdl_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int nb;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int k = 0; k < nb; k++) mdl[a+k] = d[8*k +: 8];
  endtask

  task automatic mdl_zero();
    for (int k = 0; k < DEPTH*4; k++) mdl[k] = 8'h00;
  endtask

  // Accept observer: predicts the response for the following cycle
  always @(posedge clk) begin : obs
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
    end else if (req_i && ready_o) begin
      e.cyc = cyc + 1;
      e.err = mdl_err(size_i, addr_i);
      if (e.err || we_i) e.data = 32'h0;
      else               e.data = mdl_load(size_i, unsigned_i, addr_i);
      if (!e.err && we_i) mdl_store(size_i, addr_i, wdata_i);
      sbq.push_back(e);
    end
    cyc = cyc + 1;
  end

  // Monitor: pops the scoreboard whenever a response is presented
  always @(negedge clk) begin : mon
    exp_t e;
    if (rsp_valid_o) begin
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp cyc=%0d got err=%0b rdata=%h, none expected",
                 cyc, err_o, rdata_o);
      end else begin
        e = sbq.pop_front();
        if (e.cyc != cyc || e.err !== err_o || e.data !== rdata_o) begin
          n_fail++;
          $display("FAIL rsp cyc=%0d got err=%0b rdata=%h, expected cyc=%0d err=%0b rdata=%h",
                   cyc, err_o, rdata_o, e.cyc, e.err, e.data);
        end
      end
    end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_rsp cyc=%0d got no rsp_valid, expected one for cyc=%0d",
               cyc, sbq[0].cyc);
      void'(sbq.pop_front());
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    req_i = 1'b1; we_i = w; size_i = sz; unsigned_i = u; addr_i = a; wdata_i = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Releases reset and measures the CLEAR length in cycles
  task automatic release_and_clear(output int n);
    n = 0;
    rst_n = 1'b1;
    while (n < 2000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ready_o) break;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          n;
    logic [1:0]  sz;
    logic [31:0] a;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready",     {31'h0, ready_o},     32'h0);
    chk("rst_init_done", {31'h0, init_done_o}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    chk("rst_rdata",     rdata_o,              32'h0);
    chk("rst_err",       {31'h0, err_o},       32'h0);

    // T1: clear length and zeroed contents
    mdl_zero();
    release_and_clear(n);
    chk("clear_len",       n,                     DEPTH);
    chk("init_done_after", {31'h0, init_done_o},  32'h1);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_03FC, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    idle(2);

    // T2: loads of each width and extension from one stored word
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h8040_20F1);
    idle(1);
    issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    idle(2);

    // T3: partial stores merge into an existing word
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFAA);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    idle(2);

    // T4: error cases leave memory untouched
    issue(1'b0, 2'b01, 1'b0, 32'h03, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h06, 32'hDEAD_BEEF);
    issue(1'b1, 2'b11, 1'b0, 32'h08, 32'hCAFE_F00D);
    issue(1'b0, 2'b11, 1'b0, 32'h08, 32'h0);
    issue(1'b0, 2'b10, 1'b0, DEPTH*4, 32'h0);
    issue(1'b1, 2'b10, 1'b0, DEPTH*4, 32'h1234_5678);
    issue(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    idle(2);

    // T5: back-to-back store then load of the same word
    issue(1'b1, 2'b10, 1'b0, 32'h40, 32'h0000_0005);
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    idle(2);

    // Randomised traffic with gaps, misalignment and out-of-range addresses
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        sz = 2'($urandom_range(0, 3));
        a  = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) begin
          if (sz == 2'b01) a = a & 32'hFFFF_FFFE;
          if (sz == 2'b10) a = a & 32'hFFFF_FFFC;
        end
        if ($urandom_range(0, 15) == 0) a = 32'(DEPTH*4) + 32'($urandom_range(0, 255));
        if ($urandom_range(0, 31) == 0) a = $urandom;
        issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      end
    end
    idle(3);
    chk("scoreboard_drained", sbq.size(), 32'h0);

    // T6: reset mid-clear restarts the clear; held request waits for it
    rst_n = 1'b0;
    mdl_zero();
    idle(2);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midclr_rst_ready", {31'h0, ready_o},     32'h0);
    chk("midclr_rst_valid", {31'h0, rsp_valid_o}, 32'h0);
    req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0; addr_i = 32'h40;
    rst_n = 1'b1;
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (rsp_valid_o) break;
    end
    chk("first_rsp_after_clear", n, DEPTH + 1);
    idle(3);
    chk("scoreboard_drained_end", sbq.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
